grey_edge_detect: RTL
=====================

Name: grey_edge_detect

Overview:
- Downstream neighbour of the greyscale stage, consuming its AXI4-Stream video output of 24-bit pixels in which every channel is equal.
- Computes a horizontal gradient magnitude |p[x] - p[x-1]| per pixel. Output is either the magnitude itself or a binary edge map against a runtime threshold.
- Checks line length and counts frames. Forwards the stream 1:1, with tuser and tlast preserved, to the video output bridge.

Parameters:
H_ACTIVE, 1920, expected pixels per line; sets the line-length check
XW, 12, width of the pixel column counter; must satisfy 2^XW > H_ACTIVE
FW, 16, width of the frame counter

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
s_axis_video_tdata  in  24  grey pixel; only [7:0] is used
s_axis_video_tvalid  in  1  input valid
s_axis_video_tready  out  1  input ready
s_axis_video_tuser  in  1  start of frame (first pixel)
s_axis_video_tlast  in  1  end of line
m_axis_video_tdata  out  24  {e,e,e}, where e is the 8-bit edge value
m_axis_video_tvalid  out  1  output valid
m_axis_video_tready  in  1  downstream ready
m_axis_video_tuser  out  1  start of frame, delayed with its pixel
m_axis_video_tlast  out  1  end of line, delayed with its pixel
cfg_binary  in  1  1: e = (mag >= cfg_thresh) ? 8'hFF : 8'h00; 0: e = mag
cfg_thresh  in  8  binary threshold, sampled on each accepted beat
stat_clr  in  1  clears the sticky error flags
stat_short_line  out  1  sticky: tlast seen before H_ACTIVE pixels
stat_long_line  out  1  sticky: H_ACTIVE pixels passed without tlast
stat_frame_cnt  out  FW  count of tuser beats accepted; wraps

Behaviour:
- Reset: all registered outputs are 0. That covers m tvalid, tdata, tuser and tlast, all stat_* outputs, the column counter, the previous-pixel register, and the line-start flag (line_start reset value is 1).
- Handshake:
  - s_axis_video_tready = !m_axis_video_tvalid || m_axis_video_tready (combinational). Reset forces m_axis_video_tvalid = 0, so tready is 1 during reset.
  - An input is accepted when s tvalid and s tready are both high.
  - An output beat retires when m tvalid and m tready are both high.
  - Accept while full with a simultaneous retire: the register reloads in the same cycle with no bubble. Sustains 1 pixel/clk.
  - Output holds tdata, tuser and tlast stable while tvalid && !tready.
- Latency: exactly 1 cycle from accept to m_axis_video_tvalid.
- Arithmetic:
  - mag = |p - prev|, computed as an 8-bit unsigned absolute difference with a 9-bit intermediate; never negative and never overflows.
  - When line_start is 1 or tuser is 1, prev is treated as p, so mag = 0.
  - prev <= p on every accept.
- Line tracking, updated on accept only:
  - tuser = 1: x <= 1 and line_start <= 0, and stat_frame_cnt increments (wraps at 2^FW).
  - tuser = 1 with tlast = 1 on the same beat is a 1-pixel line. The tlast rule below takes precedence for x and line_start, and the frame count still increments.
  - tlast = 1: if x != H_ACTIVE-1, set stat_short_line. Then x <= 0 and line_start <= 1.
  - Otherwise, if x == H_ACTIVE-1 (this beat is pixel H_ACTIVE with no tlast), set stat_long_line. x saturates at H_ACTIVE-1 until tlast.
  - Otherwise x <= x+1 and line_start <= 0.
- Status:
  - stat_clr has priority over a set in the same cycle; a flag set in the cycle after clr persists.
  - stat_frame_cnt is cleared only by reset.
- Stalls: no state changes unless an input beat is accepted. Inputs are ignored while s tready = 0.
- Reset mid-line: the next pixel is treated as line start.

Decomposition:
- Package grey_edge_pkg holds:
  - pixel_t (logic [7:0]);
  - function abs_diff8(a, b) returning pixel_t;
  - localparam PIX_W = 8;
  - enum edge_mode_e {EDGE_MAG, EDGE_BIN}, mapped onto cfg_binary.
- One sub-module, video_line_tracker. It owns x, line_start, stat_frame_cnt and the sticky flags. Inputs: accept, tuser, tlast, stat_clr.
- The top level contains the datapath and the output register.

Test Plan:
- Single line, H_ACTIVE = 4, cfg_binary = 0, pixels 10, 30, 25, 25 with tuser on the first and tlast on the last, m tready held 1:
  - output e = 0, 20, 5, 0 one cycle after each accept;
  - tdata = {e,e,e}, tuser and tlast aligned;
  - no stat flags set.
- Binary mode, cfg_thresh = 15, same pixels -> e = 00, FF, 00, 00.
- Backpressure:
  - m tready toggles 1010… while input is streamed continuously;
  - no beat lost or duplicated, and the output stays stable while stalled;
  - s tready = 0 exactly in the cycles where the output is full and not ready.
- Line-boundary reset of prev: line 1 ends with 200, line 2 starts with 50 -> first output of line 2 is 0, not 150.
- Length errors and stat_clr:
  - a 3-pixel line with H_ACTIVE = 4 sets stat_short_line;
  - a 6-pixel line sets stat_long_line;
  - a pulse on stat_clr clears both;
  - stat_clr asserted in the same cycle as a new error leaves the flag at 0.
- Frame count:
  - 3 frames give stat_frame_cnt = 3;
  - with FW = 2, 5 frames give 1;
  - asserting aresetn low mid-line zeroes outputs and counters, and the first post-reset pixel yields e = 0.

Source files
------------

// File: rtl/grey_edge_detect_pkg.sv
// Shared types and helpers for the greyscale edge-detect stage.
package grey_edge_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Selected by cfg_binary: raw gradient magnitude or thresholded edge map.
  typedef enum logic {
    EDGE_MAG = 1'b0,
    EDGE_BIN = 1'b1
  } edge_mode_e;

  // Unsigned |a - b|; the extra bit of the intermediate carries the sign,
  // so the result never wraps.
  function automatic pixel_t abs_diff8(input pixel_t a, input pixel_t b);
    logic [PIX_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[PIX_W]) begin
      d = {1'b0, b} - {1'b0, a};
    end
    return d[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/grey_edge_detect_if.sv
// AXI4-Stream video link carrying 24-bit pixels with start-of-frame and end-of-line.
interface grey_edge_detect_if;
  import grey_edge_pkg::*;

  logic [3*PIX_W-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tuser;
  logic               tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/grey_edge_detect_line_tracker.sv
// Tracks the pixel column within a line, flags short/long lines and counts frames.
// All state moves only on accepted beats; the sticky flags can also be cleared.
module video_line_tracker #(
  parameter int H_ACTIVE = 1920,
  parameter int XW       = 12,
  parameter int FW       = 16
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          accept,
  input  logic          tuser,
  input  logic          tlast,
  input  logic          stat_clr,
  output logic          line_start,
  output logic          stat_short_line,
  output logic          stat_long_line,
  output logic [FW-1:0] stat_frame_cnt
);

  // Column index of the last pixel of a correctly sized line.
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);

  logic [XW-1:0] x;
  logic [XW-1:0] col;
  logic          short_set;
  logic          long_set;

  // A start-of-frame beat is always column 0, whatever x held before it.
  always_comb begin
    col       = tuser ? '0 : x;
    short_set = accept && tlast && (col != X_LAST);
    long_set  = accept && !tlast && !tuser && (x == X_LAST);
  end

  // Column counter and line-start flag; tlast wins over tuser for both.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      x          <= '0;
      line_start <= 1'b1;
    end else if (accept) begin
      if (tlast) begin
        x          <= '0;
        line_start <= 1'b1;
      end else if (tuser) begin
        x          <= XW'(1);
        line_start <= 1'b0;
      end else if (x == X_LAST) begin
        line_start <= 1'b0;
      end else begin
        x          <= x + XW'(1);
        line_start <= 1'b0;
      end
    end
  end

  // Sticky length-error flags; a clear beats a set arriving in the same cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_short_line <= 1'b0;
      stat_long_line  <= 1'b0;
    end else if (stat_clr) begin
      stat_short_line <= 1'b0;
      stat_long_line  <= 1'b0;
    end else begin
      if (short_set) stat_short_line <= 1'b1;
      if (long_set)  stat_long_line  <= 1'b1;
    end
  end

  // Free-running frame counter, wraps naturally at its width.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_frame_cnt <= '0;
    end else if (accept && tuser) begin
      stat_frame_cnt <= stat_frame_cnt + FW'(1);
    end
  end

endmodule

// File: rtl/grey_edge_detect.sv
// Horizontal gradient edge detector on a greyscale AXI4-Stream video feed.
// One register stage: e = |p[x] - p[x-1]| (or its thresholded form), 1 pixel/clk.
module grey_edge_detect
  import grey_edge_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int XW       = 12,
  parameter int FW       = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  grey_edge_detect_if.slave     s_axis_video,
  grey_edge_detect_if.master    m_axis_video,
  input  logic                  cfg_binary,
  input  pixel_t                cfg_thresh,
  input  logic                  stat_clr,
  output logic                  stat_short_line,
  output logic                  stat_long_line,
  output logic [FW-1:0]         stat_frame_cnt
);

  logic       in_ready;
  logic       accept;
  logic       line_start;
  pixel_t     pix;
  pixel_t     prev;
  pixel_t     mag;
  pixel_t     edge_val;
  edge_mode_e mode;
  logic       unused_hi_bytes;

  // All three channels carry the same grey value, so only the low byte matters.
  assign unused_hi_bytes = ^s_axis_video.tdata[3*PIX_W-1:PIX_W];

  // Ready whenever the output slot is empty or is being drained this cycle.
  always_comb begin
    in_ready              = !m_axis_video.tvalid || m_axis_video.tready;
    accept                = s_axis_video.tvalid && in_ready;
    s_axis_video.tready   = in_ready;
  end

  // Gradient against the previous pixel; the first pixel of a line has none.
  always_comb begin
    pix  = s_axis_video.tdata[PIX_W-1:0];
    mode = edge_mode_e'(cfg_binary);
    mag  = (line_start || s_axis_video.tuser) ? '0 : abs_diff8(pix, prev);
    case (mode)
      EDGE_BIN: edge_val = (mag >= cfg_thresh) ? 8'hFF : 8'h00;
      default:  edge_val = mag;
    endcase
  end

  // Output register with previous-pixel capture; reloads on accept, drains on ready.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_video.tvalid <= 1'b0;
      m_axis_video.tdata  <= '0;
      m_axis_video.tuser  <= 1'b0;
      m_axis_video.tlast  <= 1'b0;
      prev                <= '0;
    end else if (accept) begin
      m_axis_video.tvalid <= 1'b1;
      m_axis_video.tdata  <= {3{edge_val}};
      m_axis_video.tuser  <= s_axis_video.tuser;
      m_axis_video.tlast  <= s_axis_video.tlast;
      prev                <= pix;
    end else if (m_axis_video.tready) begin
      m_axis_video.tvalid <= 1'b0;
    end
  end

  video_line_tracker #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .FW       (FW)
  ) u_tracker (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .accept          (accept),
    .tuser           (s_axis_video.tuser),
    .tlast           (s_axis_video.tlast),
    .stat_clr        (stat_clr),
    .line_start      (line_start),
    .stat_short_line (stat_short_line),
    .stat_long_line  (stat_long_line),
    .stat_frame_cnt  (stat_frame_cnt)
  );

endmodule
